// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle for the iterative multiply/divide
//               unit. The master drives the request (start, op, a, b) and
//               the abort (kill); the slave returns busy, the one-cycle done
//               pulse and the registered result.
// Ports       : start  - request, sampled only while the unit is idle
//               op     - RISC-V M funct3 opcode
//               a, b   - operands rs1 / rs2
//               kill   - abort of the operation in flight
//               busy   - unit is computing or presenting a result
//               done   - single-cycle pulse, result valid in that cycle
//               result - registered result, held until the next done
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, kill,
        output busy, done, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RISC-V M-extension multiply/divide unit. Works on
//               operand magnitudes: one shift-add step per cycle for
//               multiply, one restoring-subtract step per cycle for divide,
//               XLEN steps per operation, with sign fix-up applied when the
//               result register is loaded. Divide-by-zero and signed
//               overflow complete without iterating.
// Ports       : clk   - clock, rising edge
//               reset - asynchronous, active-high reset
//               bus   - muldiv_unit_if slave modport (start/op/a/b/kill in,
//                       busy/done/result out)
// Parameters  : XLEN  - operand/result width (8, 16, 32 or 64)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic    clk,
    input  wire logic    reset,
    muldiv_unit_if.slave bus
);

    localparam int c_CW = $clog2(XLEN);

    localparam logic [2:0] c_OP_MUL    = 3'b000;
    localparam logic [2:0] c_OP_MULH   = 3'b001;
    localparam logic [2:0] c_OP_MULHSU = 3'b010;
    localparam logic [2:0] c_OP_MULHU  = 3'b011;
    localparam logic [2:0] c_OP_DIV    = 3'b100;
    localparam logic [2:0] c_OP_DIVU   = 3'b101;
    localparam logic [2:0] c_OP_REM    = 3'b110;
    localparam logic [2:0] c_OP_REMU   = 3'b111;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [2:0]      r_op;
    logic            r_sa;
    logic            r_sb;
    logic [XLEN-1:0] r_mag_a;
    logic [XLEN-1:0] r_mag_b;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [c_CW-1:0] r_cnt;
    logic [XLEN-1:0] r_result;

    logic w_load;
    logic w_spec_load;
    logic w_iter;
    logic w_finish;

    // ------------------------------------------------------------------
    // Request decode on the live inputs (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_a_signed = (bus.op != c_OP_MULHU) && (bus.op != c_OP_DIVU) &&
                        (bus.op != c_OP_REMU);
    assign w_b_signed = (bus.op == c_OP_MUL) || (bus.op == c_OP_MULH) ||
                        (bus.op == c_OP_DIV) || (bus.op == c_OP_REM);
    assign w_sa       = w_a_signed & bus.a[XLEN-1];
    assign w_sb       = w_b_signed & bus.b[XLEN-1];
    // The magnitude of the most-negative value is itself, read unsigned.
    assign w_mag_a    = w_sa ? (-bus.a) : bus.a;
    assign w_mag_b    = w_sb ? (-bus.b) : bus.b;
    assign w_b_zero   = (bus.b == '0);
    assign w_ovf      = ((bus.op == c_OP_DIV) || (bus.op == c_OP_REM)) &&
                        (bus.a == c_MOST_NEG) && (bus.b == '1);
    assign w_special  = bus.op[2] && (w_b_zero || w_ovf);

    // Divide by zero: quotient all ones, remainder = a.
    // Overflow: quotient = most-negative (which is a), remainder = 0.
    always_comb begin
        w_special_res = '0;
        if (bus.op[1]) begin
            w_special_res = w_b_zero ? bus.a : '0;
        end else begin
            w_special_res = w_b_zero ? '1 : bus.a;
        end
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    logic [XLEN:0]   w_mul_sum;
    // Divide: hi is the partial remainder, lo shifts dividend out and
    // quotient bits in.
    logic [XLEN:0]   w_div_shift;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ge;
    logic [XLEN-1:0] w_hi_nxt;
    logic [XLEN-1:0] w_lo_nxt;

    assign w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag_a} : {(XLEN+1){1'b0}});
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mag_b};
    // Partial remainder is always below the divisor, so the shifted value
    // is below 2*divisor and the difference MSB is a clean borrow flag.
    assign w_div_ge    = ~w_div_diff[XLEN];

    always_comb begin
        w_hi_nxt = r_hi;
        w_lo_nxt = r_lo;
        if (r_op[2]) begin
            w_hi_nxt = w_div_ge ? w_div_diff[XLEN-1:0] : w_div_shift[XLEN-1:0];
            w_lo_nxt = {r_lo[XLEN-2:0], w_div_ge};
        end else begin
            w_hi_nxt = w_mul_sum[XLEN:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign fix-up and result selection, taken from the final step's values
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_prod   = {w_hi_nxt, w_lo_nxt};
    assign w_prod_s = (r_sa ^ r_sb) ? (-w_prod) : w_prod;
    assign w_quo    = (r_sa ^ r_sb) ? (-w_lo_nxt) : w_lo_nxt;
    assign w_rem    = r_sa ? (-w_hi_nxt) : w_hi_nxt;

    always_comb begin
        w_final = '0;
        if (r_op[2]) begin
            w_final = r_op[1] ? w_rem : w_quo;
        end else if (r_op == c_OP_MUL) begin
            w_final = w_prod_s[XLEN-1:0];
        end else begin
            w_final = w_prod_s[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_spec_load = 1'b0;
        w_iter      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A simultaneous kill cancels the request.
                if (bus.start && !bus.kill) begin
                    if (w_special) begin
                        w_spec_load = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                // Kill outranks the final step so no result is written.
                if (bus.kill) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_iter = 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        w_finish    = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op     <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mag_a  <= '0;
            r_mag_b  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_load) begin
                r_op    <= bus.op;
                r_sa    <= w_sa;
                r_sb    <= w_sb;
                r_mag_a <= w_mag_a;
                r_mag_b <= w_mag_b;
                r_hi    <= '0;
                // Divide shifts the dividend through lo; multiply shifts
                // the multiplier through lo.
                r_lo    <= bus.op[2] ? w_mag_a : w_mag_b;
                r_cnt   <= '0;
            end
            if (w_iter) begin
                r_hi  <= w_hi_nxt;
                r_lo  <= w_lo_nxt;
                r_cnt <= r_cnt + c_CW'(1);
            end
            if (w_finish) begin
                r_result <= w_final;
            end
            if (w_spec_load) begin
                r_result <= w_special_res;
            end
        end
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed self-checking bench for muldiv_unit at XLEN=32.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request, scramble the operands after the start edge, and
    // return the result plus latency (1 = done already after the start edge).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = OP_MULHU;
        bus.a = 32'h1234_5678; bus.b = 32'h0000_0003;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (bus.done !== 1'b1) begin
            fails++;
            $display("FAIL timeout op=%b: done never seen within %0d cycles", op, lat);
        end
        res = bus.result;
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 0", bus.result); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [31:0] r; int lat; logic [31:0] held;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat);
        tests++; if (r !== 32'hFFFF_FFEB) begin fails++; $display("FAIL mul_7_m3: got %h want ffffffeb", r); end
        tests++; if (lat != 33) begin fails++; $display("FAIL mul_latency: got %0d want 33", lat); end
        held = r;
        @(posedge clk); #1;
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL done_single_cycle: got %b want 0", bus.done); end
        tests++; if (bus.result !== held) begin fails++; $display("FAIL result_hold: got %h want %h", bus.result, held); end
        run_op(OP_MULH, 32'd7, 32'hFFFF_FFFD, r, lat);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mulh_7_m3: got %h want ffffffff", r); end
        run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        tests++; if (r !== 32'hFFFF_FFFE) begin fails++; $display("FAIL mulhu_max: got %h want fffffffe", r); end
        run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mulhsu_m1: got %h want ffffffff", r); end
        run_op(OP_MUL, 32'h0001_0003, 32'h0002_0005, r, lat);
        tests++; if (r !== 32'h000B_000F) begin fails++; $display("FAIL mul_low: got %h want 000b000f", r); end
    endtask

    task automatic test_div();
        logic [31:0] r; int lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
        tests++; if (r !== 32'hFFFF_FFFD) begin fails++; $display("FAIL div_m7_2: got %h want fffffffd", r); end
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rem_m7_2: got %h want ffffffff", r); end
        run_op(OP_DIVU, 32'd100, 32'd7, r, lat);
        tests++; if (r !== 32'd14) begin fails++; $display("FAIL divu_100_7: got %h want 0000000e", r); end
        tests++; if (lat != 33) begin fails++; $display("FAIL divu_latency: got %0d want 33", lat); end
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, r, lat);
        tests++; if (r !== 32'd1) begin fails++; $display("FAIL rem_7_m2: got %h want 00000001", r); end
    endtask

    task automatic test_special();
        logic [31:0] r; int lat;
        run_op(OP_DIVU, 32'd5, 32'd0, r, lat);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL divu_by0: got %h want ffffffff", r); end
        tests++; if (lat != 1) begin fails++; $display("FAIL special_latency: got %0d want 1", lat); end
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        tests++; if (r !== 32'h0) begin fails++; $display("FAIL rem_ovf: got %h want 00000000", r); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        tests++; if (r !== 32'h8000_0000) begin fails++; $display("FAIL div_ovf: got %h want 80000000", r); end
        run_op(OP_REM, 32'hFFFF_FFFB, 32'd0, r, lat);
        tests++; if (r !== 32'hFFFF_FFFB) begin fails++; $display("FAIL rem_by0: got %h want fffffffb", r); end
        run_op(OP_DIV, 32'd9, 32'd0, r, lat);
        tests++; if (r !== 32'hFFFF_FFFF) begin fails++; $display("FAIL div_by0: got %h want ffffffff", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; int lat;
        run_op(OP_MUL, 32'd3, 32'd5, r, lat);
        tests++; if (r !== 32'd15) begin fails++; $display("FAIL b2b_first: got %h want 0000000f", r); end
        // Start raised during DONE: ignored there, taken in the next IDLE cycle.
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: busy got %b want 0", bus.busy); end
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        tests++; if (lat != 33) begin fails++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        tests++; if (bus.result !== 32'd14) begin fails++; $display("FAIL b2b_result: got %h want 0000000e", bus.result); end
    endtask

    task automatic test_kill();
        logic [31:0] prev; logic [31:0] r; int lat; int ndone;
        prev = bus.result;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd1000; bus.b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL kill_busy: got %b want 0", bus.busy); end
        ndone = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) ndone++; end
        tests++; if (ndone != 0) begin fails++; $display("FAIL kill_no_done: got %0d pulses want 0", ndone); end
        tests++; if (bus.result !== prev) begin fails++; $display("FAIL kill_result: got %h want %h", bus.result, prev); end
        // kill together with start in IDLE cancels the request
        bus.start = 1'b1; bus.kill = 1'b1; bus.op = OP_MUL; bus.a = 32'd2; bus.b = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL kill_start_idle: busy got %b want 0", bus.busy); end
        run_op(OP_MUL, 32'd6, 32'd7, r, lat);
        tests++; if (r !== 32'd42) begin fails++; $display("FAIL after_kill: got %h want 0000002a", r); end
    endtask

    task automatic test_reset_mid();
        int ndone; int lat;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.result !== 32'h0) begin fails++; $display("FAIL midreset_result: got %h want 0", bus.result); end
        @(posedge clk); #1;
        reset = 1'b0;
        bus.start = 1'b1; bus.op = OP_MUL; bus.a = 32'd6; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL first_start_after_reset: busy got %b want 1", bus.busy); end
        // start pulses while busy must be ignored
        repeat (3) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        ndone = 0; lat = 0;
        repeat (60) begin
            if (bus.done === 1'b1) begin
                ndone++;
                tests++; if (bus.result !== 32'd42) begin fails++; $display("FAIL busy_start_result: got %h want 0000002a", bus.result); end
            end
            @(posedge clk); #1;
        end
        tests++; if (ndone != 1) begin fails++; $display("FAIL busy_start_ignored: got %0d done pulses want 1", ndone); end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b0;
        bus.start = 1'b0; bus.kill = 1'b0; bus.op = 3'b000;
        bus.a = 32'h0; bus.b = 32'h0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_back_to_back();
        test_kill();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
